// File: rtl/serial_frame_tx.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | serial_frame_tx: parallel request -> start/port/len/payload bit frame  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module serial_frame_tx #(
  parameter  int LEN_W  = 4,
  parameter  int PORT_W = 2,
  localparam int MAX_D  = (1 << LEN_W) - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en_i,
  input  logic              start_i,
  input  logic [PORT_W-1:0] port_sel_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [MAX_D-1:0]  data_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              ser_out_o,
  output logic              done_o,
  output logic [4:0]        bits_left_o
);

  localparam int BL_W  = 5;
  localparam int CNT_W = LEN_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_PORT  = 3'd2,
    S_LEN   = 3'd3,
    S_DATA  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [PORT_W-1:0]   port_q,  port_d;
  logic [LEN_W-1:0]    lensh_q, lensh_d;
  logic [LEN_W-1:0]    len_q,   len_d;
  logic [MAX_D-1:0]    data_q,  data_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [BL_W-1:0]     bl_q,    bl_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      port_q  <= '0;
      lensh_q <= '0;
      len_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      bl_q    <= '0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      lensh_q <= lensh_d;
      len_q   <= len_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      bl_q    <= bl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    lensh_d = lensh_q;
    len_d   = len_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    bl_d    = bl_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_START;
          port_d  = port_sel_i;
          lensh_d = len_i;
          len_d   = len_i;
          // MAX_D - len == ~len; shifting left discards unused upper payload bits
          data_d  = data_i << (~len_i);
          bl_d    = BL_W'(1 + PORT_W + LEN_W) + BL_W'(len_i);
        end
      end
      S_START: begin
        if (clk_en_i) begin
          state_d = S_PORT;
          cnt_d   = CNT_W'(PORT_W);
          bl_d    = bl_q - BL_W'(1);
        end
      end
      S_PORT: begin
        if (clk_en_i) begin
          port_d = port_q << 1;
          cnt_d  = cnt_q - CNT_W'(1);
          bl_d   = bl_q - BL_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_LEN;
            cnt_d   = CNT_W'(LEN_W);
          end
        end
      end
      S_LEN: begin
        if (clk_en_i) begin
          lensh_d = lensh_q << 1;
          cnt_d   = cnt_q - CNT_W'(1);
          bl_d    = bl_q - BL_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            cnt_d   = CNT_W'(len_q);
            state_d = (len_q == '0) ? S_DONE : S_DATA;
          end
        end
      end
      S_DATA: begin
        if (clk_en_i) begin
          data_d = data_q << 1;
          cnt_d  = cnt_q - CNT_W'(1);
          bl_d   = bl_q - BL_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs depend on registered state only, so the line cannot glitch with start/clk_en
  always_comb begin
    ser_out_o = 1'b1;
    unique case (state_q)
      S_START: ser_out_o = 1'b0;
      S_PORT:  ser_out_o = port_q[PORT_W-1];
      S_LEN:   ser_out_o = lensh_q[LEN_W-1];
      S_DATA:  ser_out_o = data_q[MAX_D-1];
      default: ser_out_o = 1'b1;
    endcase
  end

  assign ready_o     = (state_q == S_IDLE);
  assign busy_o      = ~ready_o;
  assign done_o      = (state_q == S_DONE);
  assign bits_left_o = bl_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
`default_nettype none
// Testbench for serial_frame_tx: directed table frames plus random frames vs. a bit-list model.
module tb_serial_frame_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en_i;
  logic        start_i;
  logic [1:0]  port_sel_i;
  logic [3:0]  len_i;
  logic [14:0] data_i;
  logic        ready_o, busy_o, ser_out_o, done_o;
  logic [4:0]  bits_left_o;

  int n_tests = 0;
  int n_fail  = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  serial_frame_tx #(.LEN_W(4), .PORT_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en_i   (clk_en_i),
    .start_i    (start_i),
    .port_sel_i (port_sel_i),
    .len_i      (len_i),
    .data_i     (data_i),
    .ready_o    (ready_o),
    .busy_o     (busy_o),
    .ser_out_o  (ser_out_o),
    .done_o     (done_o),
    .bits_left_o(bits_left_o)
  );

  typedef struct {
    logic [1:0]  port;
    logic [3:0]  len;
    logic [14:0] data;
    int          per;
    int          rst_at;
    int          restart_at;
    logic [21:0] bits;
    int          nbits;
  } vec_t;

  task automatic chk(input string nm, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference frame: start 0, port MSB first, len MSB first, data[len-1]..data[0]
  task automatic build_model(input logic [1:0] p, input logic [3:0] l, input logic [14:0] d);
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 1; i >= 0; i--) exp_q.push_back(p[i]);
    for (int i = 3; i >= 0; i--) exp_q.push_back(l[i]);
    for (int i = int'(l) - 1; i >= 0; i--) exp_q.push_back(d[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", int'(ready_o), 1);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_ser", int'(ser_out_o), 1);
    chk("rst_done", int'(done_o), 0);
    chk("rst_bits_left", int'(bits_left_o), 0);
  endtask

  // Sends one frame, checking every cycle against exp_q. per=0 -> random strobes.
  task automatic send_frame(input logic [1:0] p, input logic [3:0] l, input logic [14:0] d,
                            input int per, input int rst_at, input int restart_at);
    int n, k, cyc;
    bit restarted;
    n = exp_q.size();
    k = 0;
    cyc = 0;
    restarted = 0;
    @(negedge clk);
    chk("idle_ready", int'(ready_o), 1);
    start_i    = 1'b1;
    port_sel_i = p;
    len_i      = l;
    data_i     = d;
    clk_en_i   = 1'b1;
    while (k < n && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start_i    = 1'b0;
      port_sel_i = 2'($urandom);
      len_i      = 4'($urandom);
      data_i     = 15'($urandom);
      chk("ser_bit", int'(ser_out_o), int'(exp_q[k]));
      chk("bits_left", int'(bits_left_o), n - k);
      chk("busy_done", int'(done_o), 0);
      chk("busy_ready", int'(ready_o), 0);
      if (k == rst_at) begin
        rst      = 1'b1;
        clk_en_i = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        clk_en_i = 1'b0;
        chk("midrst_ser", int'(ser_out_o), 1);
        chk("midrst_ready", int'(ready_o), 1);
        chk("midrst_bits_left", int'(bits_left_o), 0);
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          clk_en_i = 1'b1;
          chk("midrst_no_done", int'(done_o), 0);
          chk("midrst_idle", int'(ready_o), 1);
        end
        clk_en_i = 1'b0;
        return;
      end
      if (k == restart_at && !restarted) begin
        start_i   = 1'b1;
        restarted = 1;
      end
      clk_en_i = (per == 0) ? 1'($urandom) : ((cyc % per) == 0);
      if (clk_en_i) k++;
    end
    if (k < n) begin
      chk("frame_timeout", k, n);
      return;
    end
    @(negedge clk);
    clk_en_i = 1'($urandom);
    start_i  = 1'b1;
    chk("done_pulse", int'(done_o), 1);
    chk("done_ser", int'(ser_out_o), 1);
    chk("done_ready", int'(ready_o), 0);
    chk("done_busy", int'(busy_o), 1);
    chk("done_bits_left", int'(bits_left_o), 0);
    @(negedge clk);
    start_i  = 1'b0;
    clk_en_i = 1'b0;
    chk("after_done", int'(done_o), 0);
    chk("after_ready", int'(ready_o), 1);
    @(negedge clk);
    chk("done_start_ignored", int'(ready_o), 1);
    chk("idle_ser", int'(ser_out_o), 1);
  endtask

  vec_t vecs[6];

  initial begin
    rst = 1'b1;
    clk_en_i = 1'b0;
    start_i = 1'b0;
    port_sel_i = '0;
    len_i = '0;
    data_i = '0;

    vecs[0] = '{2'b10, 4'd3,  15'b101,    4, -1, -1, 22'b0100011101, 10};
    vecs[1] = '{2'b11, 4'd0,  15'h5A5A,   3, -1, -1, 22'b0110000, 7};
    vecs[2] = '{2'b00, 4'd15, 15'h7FFF,   2, -1, -1, 22'b0001111111111111111111, 22};
    vecs[3] = '{2'b10, 4'd3,  15'h7FF5,   4, -1,  2, 22'b0100011101, 10};
    vecs[4] = '{2'b00, 4'd15, 15'h7FFF,   1, 10, -1, 22'b0001111111111111111111, 22};
    vecs[5] = '{2'b10, 4'd3,  15'b101,    4, -1, -1, 22'b0100011101, 10};

    do_reset();
    for (int v = 0; v < 6; v++) begin
      exp_q.delete();
      for (int i = vecs[v].nbits - 1; i >= 0; i--) exp_q.push_back(vecs[v].bits[i]);
      send_frame(vecs[v].port, vecs[v].len, vecs[v].data,
                 vecs[v].per, vecs[v].rst_at, vecs[v].restart_at);
    end

    for (int r = 0; r < 40; r++) begin
      logic [1:0]  p;
      logic [3:0]  l;
      logic [14:0] d;
      int per, ra, rs;
      p   = 2'($urandom);
      l   = 4'($urandom);
      d   = 15'($urandom);
      per = int'($urandom_range(0, 4));
      ra  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 6 + int'(l))) : -1;
      rs  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6 + int'(l))) : -1;
      build_model(p, l, d);
      send_frame(p, l, d, per, ra, rs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
